// File: rtl/vproc_pkg.sv
// Shared vproc types: config-unit encodings, op payload and FSM states.
// Consumed by the UNIT_CFG execution stage and its vl calculator.
package vproc_pkg;

  typedef enum logic [1:0] {
    VSEW_8       = 2'b00,
    VSEW_16      = 2'b01,
    VSEW_32      = 2'b10,
    VSEW_INVALID = 2'b11
  } cfg_vsew;

  // Signed LMUL encoding: 0..3 integral, 5..7 fractional
  typedef enum logic [2:0] {
    LMUL_1       = 3'b000,
    LMUL_2       = 3'b001,
    LMUL_4       = 3'b010,
    LMUL_8       = 3'b011,
    LMUL_INVALID = 3'b100,
    LMUL_F8      = 3'b101,
    LMUL_F4      = 3'b110,
    LMUL_F2      = 3'b111
  } cfg_lmul;

  typedef enum logic [1:0] {
    VXRM_RNU = 2'b00,
    VXRM_RNE = 2'b01,
    VXRM_RDN = 2'b10,
    VXRM_ROD = 2'b11
  } cfg_vxrm;

  typedef enum logic [3:0] {
    CFG_VSETVL,
    CFG_VTYPE_READ,
    CFG_VL_READ,
    CFG_VLENB_READ,
    CFG_VSTART_WRITE,
    CFG_VSTART_SET,
    CFG_VSTART_CLEAR,
    CFG_VXSAT_WRITE,
    CFG_VXSAT_SET,
    CFG_VXSAT_CLEAR,
    CFG_VXRM_WRITE,
    CFG_VXRM_SET,
    CFG_VXRM_CLEAR,
    CFG_VCSR_WRITE,
    CFG_VCSR_SET,
    CFG_VCSR_CLEAR
  } cfg_csr_op;

  typedef struct packed {
    cfg_csr_op  csr_op;
    cfg_vsew    vsew;
    cfg_lmul    lmul;
    logic [1:0] agnostic;
    logic       vlmax;
    logic       keep_vl;
  } op_mode_cfg;

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_DRAIN,
    CFG_EXEC,
    CFG_RESP
  } cfg_unit_state;

  localparam int unsigned VTYPE_VILL_BIT = 31;
  localparam int unsigned VTYPE_VMA_BIT  = 7;
  localparam int unsigned VTYPE_VTA_BIT  = 6;

  // Pure reads need no ordering against older vector ops
  function automatic logic is_read_op(
    input cfg_csr_op op
  );
    return op inside {CFG_VTYPE_READ,
                      CFG_VL_READ,
                      CFG_VLENB_READ};
  endfunction

endpackage

// File: rtl/vproc_cfg_unit_if.sv
// Dispatch/result handshake bundle of the vector config unit.
// master = dispatcher side, slave = config unit side.
interface vproc_cfg_unit_if
  import vproc_pkg::*;
#(
  parameter int unsigned ID_W = 3
) ();

  logic            op_valid;
  logic            op_ready;
  logic [ID_W-1:0] op_id;
  op_mode_cfg      op_mode;
  logic [31:0]     rs1;

  logic            res_valid;
  logic            res_ready;
  logic [ID_W-1:0] res_id;
  logic [31:0]     res_data;

  modport master (
    output op_valid,
    output op_id,
    output op_mode,
    output rs1,
    output res_ready,
    input  op_ready,
    input  res_valid,
    input  res_id,
    input  res_data
  );

  modport slave (
    input  op_valid,
    input  op_id,
    input  op_mode,
    input  rs1,
    input  res_ready,
    output op_ready,
    output res_valid,
    output res_id,
    output res_data
  );

endinterface

// File: rtl/vproc_cfg_vlcalc.sv
// Combinational VLMAX, vtype legality check and vl clamp
// for vsetvl-class instructions.
module vproc_cfg_vlcalc
  import vproc_pkg::*;
#(
  parameter int unsigned VREG_W = 128,
  parameter int unsigned VL_W   = $clog2(VREG_W) + 1
) (
  input  cfg_vsew         vsew,
  input  cfg_lmul         lmul,
  input  logic [31:0]     avl,
  input  logic [VL_W-1:0] old_vl,
  input  logic            vlmax_req,
  input  logic            keep_vl,
  output logic [VL_W-1:0] vl_new,
  output logic            vill_new
);

  logic [2:0]      lmul_b;
  logic [3:0]      shamt;
  logic [VL_W-1:0] vlmax;
  logic            vtype_ok;

  // VLMAX = VREG_W >> (3 + vsew - lmul), lmul signed
  assign lmul_b = lmul;
  assign shamt  = 4'd3 + {2'b00, vsew}
                - {lmul_b[2], lmul_b};
  assign vlmax  = VL_W'(VREG_W) >> shamt;

  always_comb begin
    vtype_ok = 1'b1;
    if (vsew == VSEW_INVALID) vtype_ok = 1'b0;
    if (lmul == LMUL_INVALID) vtype_ok = 1'b0;
    if (lmul == LMUL_F8 &&
        vsew inside {VSEW_16, VSEW_32})
      vtype_ok = 1'b0;
    if (lmul == LMUL_F4 && vsew == VSEW_32)
      vtype_ok = 1'b0;
  end

  always_comb begin
    vl_new   = '0;
    vill_new = 1'b1;
    if (vtype_ok) begin
      vill_new = 1'b0;
      if (vlmax_req) begin
        vl_new = vlmax;
      end else if (keep_vl) begin
        if (old_vl > vlmax) vill_new = 1'b1;
        else                vl_new   = old_vl;
      end else if (avl > 32'(vlmax)) begin
        vl_new = vlmax;
      end else begin
        vl_new = avl[VL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/vproc_cfg_unit.sv
// UNIT_CFG execution stage: vtype/vl/vstart/vxrm/vxsat state.
// Optional vstart register: VPROC_CFG_VSTART_EN.
module vproc_cfg_unit
  import vproc_pkg::*;
#(
  parameter int unsigned VREG_W = 128,
  parameter int unsigned ID_W   = 3,
  parameter int unsigned VL_W   = $clog2(VREG_W) + 1
) (
  input  logic              clk_i,
  input  logic              sync_rst_i,
  vproc_cfg_unit_if.slave   op_if,
  input  logic              busy_i,
  input  logic              vxsat_set_i,
  output logic [1:0]        vsew_o,
  output logic [2:0]        lmul_o,
  output logic [VL_W-1:0]   vl_o,
  output logic              vl_0_o,
  output logic              vill_o,
  output logic [VL_W-1:0]   vstart_o,
  output logic [1:0]        vxrm_o,
  output logic              vxsat_o
);

`ifdef VPROC_CFG_VSTART_EN
  localparam int unsigned CSR_W = VL_W;
`else
  localparam int unsigned CSR_W = 3;
`endif

  cfg_unit_state   state_q, state_d;
  logic            accept, exec;
  logic            op_ready, res_valid;

  logic [ID_W-1:0] id_q;
  op_mode_cfg      mode_q;
  logic [31:0]     rs1_q;
  logic [31:0]     res_q, res_d;

  cfg_vsew         vsew_q;
  cfg_lmul         lmul_q;
  logic            vta_q, vma_q, vill_q;
  logic [VL_W-1:0] vl_q;
  cfg_vxrm         vxrm_q;
  logic            vxsat_q;

  logic [VL_W-1:0] calc_vl;
  logic            calc_vill;
  logic [31:0]     vtype_rd;

  logic            is_vsetvl;
  logic            grp_vstart, grp_vxsat;
  logic            grp_vxrm, grp_vcsr;
  logic            rmw_set, rmw_clr;
  logic [CSR_W-1:0] csr_old, csr_src, csr_new;

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) state_q <= CFG_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    accept    = 1'b0;
    exec      = 1'b0;
    unique case (state_q)
      CFG_IDLE: begin
        op_ready = 1'b1;
        if (op_if.op_valid) begin
          accept  = 1'b1;
          state_d = is_read_op(op_if.op_mode.csr_op)
                  ? CFG_EXEC : CFG_DRAIN;
        end
      end
      CFG_DRAIN: begin
        if (!busy_i) state_d = CFG_EXEC;
      end
      CFG_EXEC: begin
        exec    = 1'b1;
        state_d = CFG_RESP;
      end
      CFG_RESP: begin
        res_valid = 1'b1;
        if (op_if.res_ready) state_d = CFG_IDLE;
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  vproc_cfg_vlcalc #(
    .VREG_W (VREG_W),
    .VL_W   (VL_W)
  ) i_vlcalc (
    .vsew      (mode_q.vsew),
    .lmul      (mode_q.lmul),
    .avl       (rs1_q),
    .old_vl    (vl_q),
    .vlmax_req (mode_q.vlmax),
    .keep_vl   (mode_q.keep_vl),
    .vl_new    (calc_vl),
    .vill_new  (calc_vill)
  );

  always_comb begin
    vtype_rd                 = '0;
    vtype_rd[VTYPE_VILL_BIT] = vill_q;
    vtype_rd[VTYPE_VMA_BIT]  = vma_q;
    vtype_rd[VTYPE_VTA_BIT]  = vta_q;
    vtype_rd[4:3]            = vsew_q;
    vtype_rd[2:0]            = lmul_q;
  end

  assign is_vsetvl  = mode_q.csr_op == CFG_VSETVL;
  assign grp_vstart = mode_q.csr_op inside
    {CFG_VSTART_WRITE, CFG_VSTART_SET, CFG_VSTART_CLEAR};
  assign grp_vxsat  = mode_q.csr_op inside
    {CFG_VXSAT_WRITE, CFG_VXSAT_SET, CFG_VXSAT_CLEAR};
  assign grp_vxrm   = mode_q.csr_op inside
    {CFG_VXRM_WRITE, CFG_VXRM_SET, CFG_VXRM_CLEAR};
  assign grp_vcsr   = mode_q.csr_op inside
    {CFG_VCSR_WRITE, CFG_VCSR_SET, CFG_VCSR_CLEAR};
  assign rmw_set    = mode_q.csr_op inside
    {CFG_VSTART_SET, CFG_VXSAT_SET,
     CFG_VXRM_SET, CFG_VCSR_SET};
  assign rmw_clr    = mode_q.csr_op inside
    {CFG_VSTART_CLEAR, CFG_VXSAT_CLEAR,
     CFG_VXRM_CLEAR, CFG_VCSR_CLEAR};
  assign csr_src    = rs1_q[CSR_W-1:0];

  always_comb begin
    csr_old = '0;
    unique case (1'b1)
      grp_vstart: csr_old = CSR_W'(vstart_o);
      grp_vxsat:  csr_old = CSR_W'(vxsat_q);
      grp_vxrm:   csr_old = CSR_W'(vxrm_q);
      grp_vcsr:   csr_old = CSR_W'({vxrm_q, vxsat_q});
      default:    csr_old = '0;
    endcase
  end

  always_comb begin
    csr_new = csr_src;
    unique case (1'b1)
      rmw_set: csr_new = csr_old | csr_src;
      rmw_clr: csr_new = csr_old & ~csr_src;
      default: csr_new = csr_src;
    endcase
  end

  always_comb begin
    res_d = 32'(csr_old);
    unique case (mode_q.csr_op)
      CFG_VSETVL:     res_d = 32'(calc_vl);
      CFG_VTYPE_READ: res_d = vtype_rd;
      CFG_VL_READ:    res_d = 32'(vl_q);
      CFG_VLENB_READ: res_d = 32'(VREG_W / 8);
      default:        res_d = 32'(csr_old);
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      id_q   <= '0;
      mode_q <= '0;
      rs1_q  <= '0;
      res_q  <= '0;
      vill_q <= 1'b1;
      vl_q   <= '0;
      vsew_q <= VSEW_8;
      lmul_q <= LMUL_1;
      vta_q  <= 1'b0;
      vma_q  <= 1'b0;
      vxrm_q <= VXRM_RNU;
    end else begin
      if (accept) begin
        id_q   <= op_if.op_id;
        mode_q <= op_if.op_mode;
        rs1_q  <= op_if.rs1;
      end
      if (exec) begin
        res_q <= res_d;
        if (is_vsetvl) begin
          vill_q <= calc_vill;
          vl_q   <= calc_vl;
          // vill leaves the other vtype fields zero
          if (calc_vill) begin
            vsew_q <= VSEW_8;
            lmul_q <= LMUL_1;
            vta_q  <= 1'b0;
            vma_q  <= 1'b0;
          end else begin
            vsew_q <= mode_q.vsew;
            lmul_q <= mode_q.lmul;
            vta_q  <= mode_q.agnostic[0];
            vma_q  <= mode_q.agnostic[1];
          end
        end
        if (grp_vxrm)
          vxrm_q <= cfg_vxrm'(csr_new[1:0]);
        if (grp_vcsr)
          vxrm_q <= cfg_vxrm'(csr_new[2:1]);
      end
    end
  end

  // Explicit CSR write wins over a same-cycle saturation event
  always_ff @(posedge clk_i) begin
    if (sync_rst_i)
      vxsat_q <= 1'b0;
    else if (exec && (grp_vxsat || grp_vcsr))
      vxsat_q <= csr_new[0];
    else if (vxsat_set_i)
      vxsat_q <= 1'b1;
  end

`ifdef VPROC_CFG_VSTART_EN
  logic [VL_W-1:0] vstart_q;

  always_ff @(posedge clk_i) begin
    if (sync_rst_i)
      vstart_q <= '0;
    else if (exec && is_vsetvl)
      vstart_q <= '0;
    else if (exec && grp_vstart)
      vstart_q <= csr_new[VL_W-1:0];
  end

  assign vstart_o = vstart_q;
`else
  assign vstart_o = '0;
`endif

  assign op_if.op_ready  = op_ready;
  assign op_if.res_valid = res_valid;
  assign op_if.res_id    = id_q;
  assign op_if.res_data  = res_q;

  assign vsew_o  = vsew_q;
  assign lmul_o  = lmul_q;
  assign vl_o    = vl_q;
  assign vl_0_o  = vl_q == '0;
  assign vill_o  = vill_q;
  assign vxrm_o  = vxrm_q;
  assign vxsat_o = vxsat_q;

endmodule

// File: tb/tb_vproc_cfg_unit.sv
// Directed bench for vproc_cfg_unit: vsetvl, CSR ops,
// drain, backpressure and reset, hand-computed expectations.
module tb_vproc_cfg_unit;
  import vproc_pkg::*;

  localparam int unsigned VREG_W = 128;
  localparam int unsigned ID_W   = 3;
  localparam int unsigned VL_W   = 8;

`ifdef VPROC_CFG_VSTART_EN
  localparam logic [31:0] EXP_VS = 32'd5;
`else
  localparam logic [31:0] EXP_VS = 32'd0;
`endif

  logic            clk = 1'b0;
  logic            sync_rst;
  logic            busy;
  logic            vxsat_set;
  logic [1:0]      vsew;
  logic [2:0]      lmul;
  logic [VL_W-1:0] vl;
  logic            vl_0;
  logic            vill;
  logic [VL_W-1:0] vstart;
  logic [1:0]      vxrm;
  logic            vxsat;

  int              n_checks = 0;
  int              n_errors = 0;
  int              lat;
  logic [ID_W-1:0] cur_id = '0;

  vproc_cfg_unit_if #(.ID_W(ID_W)) op_if ();

  vproc_cfg_unit #(
    .VREG_W (VREG_W),
    .ID_W   (ID_W),
    .VL_W   (VL_W)
  ) dut (
    .clk_i       (clk),
    .sync_rst_i  (sync_rst),
    .op_if       (op_if),
    .busy_i      (busy),
    .vxsat_set_i (vxsat_set),
    .vsew_o      (vsew),
    .lmul_o      (lmul),
    .vl_o        (vl),
    .vl_0_o      (vl_0),
    .vill_o      (vill),
    .vstart_o    (vstart),
    .vxrm_o      (vxrm),
    .vxsat_o     (vxsat)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic op_mode_cfg mk(
    input cfg_csr_op  op,
    input cfg_vsew    s  = VSEW_8,
    input cfg_lmul    l  = LMUL_1,
    input logic [1:0] ag = 2'b00,
    input logic       vm = 1'b0,
    input logic       kv = 1'b0
  );
    op_mode_cfg m;
    m.csr_op   = op;
    m.vsew     = s;
    m.lmul     = l;
    m.agnostic = ag;
    m.vlmax    = vm;
    m.keep_vl  = kv;
    return m;
  endfunction

  task automatic issue(
    input op_mode_cfg  m,
    input logic [31:0] src
  );
    op_if.op_mode  = m;
    op_if.rs1      = src;
    op_if.op_id    = cur_id;
    op_if.op_valid = 1'b1;
    step();
    op_if.op_valid = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!op_if.res_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic run(
    input string       tag,
    input op_mode_cfg  m,
    input logic [31:0] src,
    input int          exp_lat,
    input logic [31:0] exp_res
  );
    int n;
    issue(m, src);
    wait_res(n);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_res"}, op_if.res_data, exp_res);
    check({tag, "_id"}, 32'(op_if.res_id),
          32'(cur_id));
    step();
    cur_id++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    sync_rst        = 1'b1;
    busy            = 1'b0;
    vxsat_set       = 1'b0;
    op_if.op_valid  = 1'b0;
    op_if.op_id     = '0;
    op_if.op_mode   = '0;
    op_if.rs1       = '0;
    op_if.res_ready = 1'b1;
    repeat (3) step();
    sync_rst = 1'b0;

    check("rst_op_ready", op_if.op_ready, 1);
    check("rst_res_valid", op_if.res_valid, 0);
    check("rst_res_data", op_if.res_data, 0);
    check("rst_res_id", 32'(op_if.res_id), 0);
    check("rst_vill", vill, 1);
    check("rst_vl", vl, 0);
    check("rst_vl_0", vl_0, 1);
    check("rst_vsew", vsew, 0);
    check("rst_lmul", lmul, 0);
    check("rst_vxrm", vxrm, 0);
    check("rst_vxsat", vxsat, 0);
    check("rst_vstart", vstart, 0);

    run("vtype_rst", mk(CFG_VTYPE_READ), 0, 1,
        32'h8000_0000);

    run("vset_20", mk(CFG_VSETVL, VSEW_8, LMUL_1),
        20, 2, 16);
    check("vset_20_vl", vl, 16);
    check("vset_20_vl_0", vl_0, 0);
    check("vset_20_vill", vill, 0);

    run("vset_e16",
        mk(CFG_VSETVL, VSEW_16, LMUL_2, 2'b11),
        5, 2, 5);
    run("vtype_e16", mk(CFG_VTYPE_READ), 0, 1,
        32'h0000_00C9);
    check("e16_vsew", vsew, 1);
    check("e16_lmul", lmul, 1);

    run("vset_max",
        mk(CFG_VSETVL, VSEW_32, LMUL_8, 2'b00, 1'b1),
        0, 2, 32);
    check("vset_max_vl", vl, 32);

    run("vset_keep",
        mk(CFG_VSETVL, VSEW_8, LMUL_1, 2'b00,
           1'b0, 1'b1),
        0, 2, 0);
    check("keep_vill", vill, 1);
    check("keep_vl", vl, 0);
    check("keep_vl_0", vl_0, 1);

    run("vset_f8", mk(CFG_VSETVL, VSEW_8, LMUL_F8),
        100, 2, 2);
    check("f8_vill", vill, 0);
    check("f8_vl", vl, 2);

    run("vset_ill", mk(CFG_VSETVL, VSEW_32, LMUL_F8),
        10, 2, 0);
    check("ill_vill", vill, 1);
    check("ill_vl", vl, 0);
    run("vtype_ill", mk(CFG_VTYPE_READ), 0, 1,
        32'h8000_0000);

    run("vset_big", mk(CFG_VSETVL, VSEW_8, LMUL_8),
        32'h0000_0100, 2, 128);
    run("vl_rd", mk(CFG_VL_READ), 0, 1, 128);
    run("vlenb", mk(CFG_VLENB_READ), 0, 1, 16);

    busy = 1'b1;
    issue(mk(CFG_VXRM_WRITE), 3);
    repeat (5) step();
    check("drain_valid", op_if.res_valid, 0);
    check("drain_ready", op_if.op_ready, 0);
    check("drain_vxrm", vxrm, 0);
    busy = 1'b0;
    wait_res(lat);
    check("drain_lat", lat, 2);
    check("drain_res", op_if.res_data, 0);
    check("drain_vxrm_new", vxrm, 3);
    step();
    cur_id++;

    vxsat_set = 1'b1;
    step();
    vxsat_set = 1'b0;
    check("vxsat_evt", vxsat, 1);
    run("vcsr_rd", mk(CFG_VCSR_SET), 0, 2, 7);

    issue(mk(CFG_VXSAT_CLEAR), 1);
    step();
    vxsat_set = 1'b1;
    step();
    vxsat_set = 1'b0;
    check("prio_valid", op_if.res_valid, 1);
    check("prio_res", op_if.res_data, 1);
    check("prio_vxsat", vxsat, 0);
    step();
    cur_id++;

    run("vcsr_wr", mk(CFG_VCSR_WRITE), 32'h2, 2, 6);
    check("vcsr_vxrm", vxrm, 1);
    check("vcsr_vxsat", vxsat, 0);

    run("vstart_wr", mk(CFG_VSTART_WRITE), 5, 2, 0);
    check("vstart_val", vstart, EXP_VS);
    run("vstart_rd", mk(CFG_VSTART_SET), 0, 2, EXP_VS);
    run("vset_clr", mk(CFG_VSETVL, VSEW_8, LMUL_1),
        3, 2, 3);
    check("vset_clr_vstart", vstart, 0);

    op_if.res_ready = 1'b0;
    issue(mk(CFG_VL_READ), 0);
    wait_res(lat);
    check("bp_lat", lat, 1);
    check("bp_res", op_if.res_data, 3);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_valid", op_if.res_valid, 1);
      check("bp_hold_data", op_if.res_data, 3);
      check("bp_hold_id", 32'(op_if.res_id),
            32'(cur_id));
      check("bp_op_ready", op_if.op_ready, 0);
    end
    sync_rst = 1'b1;
    step();
    check("rr_valid", op_if.res_valid, 0);
    check("rr_ready", op_if.op_ready, 1);
    check("rr_vill", vill, 1);
    check("rr_vl", vl, 0);
    check("rr_data", op_if.res_data, 0);
    sync_rst        = 1'b0;
    op_if.res_ready = 1'b1;
    cur_id++;

    run("post_rst", mk(CFG_VTYPE_READ), 0, 1,
        32'h8000_0000);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vproc_cfg_unit.md
Name: vproc_cfg_unit

Overview:
- Execution stage for UNIT_CFG pseudo-unit instructions, fed by the decoder/dispatcher with op_mode_cfg payloads.
- Owns the architectural vector configuration state: vtype (vsew, lmul, vta, vma, vill), vl, vstart, vxrm and vxsat.
- Computes vl for vsetvl* and executes all vector CSR reads and read-modify-writes.
- Returns one 32-bit result per instruction and drives the current configuration to every downstream unit.

Parameters:
- VREG_W, 128, vector register width in bits. Power of two, at least 64.
- ID_W, 3, instruction id width.
- VL_W, $clog2(VREG_W)+1, width of the vl and vstart registers.

Ports:
- clk_i  in  1  clock
- sync_rst_i  in  1  synchronous active-high reset
- op_valid_i  in  1  instruction valid
- op_ready_o  out  1  unit can accept an instruction
- op_id_i  in  ID_W  instruction id
- op_mode_i  in  13  op_mode_cfg {csr_op, vsew, lmul, agnostic, vlmax, keep_vl}
- rs1_i  in  32  AVL or CSR source value
- busy_i  in  1  older vector instructions are still in flight
- vxsat_set_i  in  1  saturation event from ALU/MUL
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result accepted
- res_id_o  out  ID_W  id of the result
- res_data_o  out  32  result data
- vsew_o  out  2  current SEW
- lmul_o  out  3  current LMUL
- vl_o  out  VL_W  current vl
- vl_0_o  out  1  vl==0
- vill_o  out  1  vtype illegal
- vstart_o  out  VL_W  current vstart
- vxrm_o  out  2  current rounding mode
- vxsat_o  out  1  current sticky saturation flag

Behaviour:
- Reset values:
  - State IDLE; op_ready_o=1; res_valid_o=0; res_id_o=0; res_data_o=0.
  - vill=1, vl=0, vsew=VSEW_8, lmul=LMUL_1, vta=vma=0, vstart=0, vxrm=VXRM_RNU, vxsat=0.
- FSM states: IDLE, DRAIN, EXEC, RESP.
  - IDLE: op_ready_o=1. On op_valid_i, latch op_id_i, op_mode_i and rs1_i.
    - CFG_VTYPE_READ, CFG_VL_READ and CFG_VLENB_READ go to EXEC.
    - All other ops go to DRAIN.
  - DRAIN: stay while busy_i=1; go to EXEC when busy_i=0.
  - EXEC: single cycle. Update state registers, capture res_data_o, assert res_valid_o, go to RESP.
  - RESP: hold res_* stable until res_ready_i. On acceptance go to IDLE. No new op is accepted in RESP.
  - op_ready_o=1 only in IDLE.
- Latency: 2 cycles from the accepting edge to res_valid_o when busy_i=0.
- vsetvl (CFG_VSETVL):
  - VLMAX = (VREG_W/8) * 2^lmul >> vsew, using signed lmul encoding (F8..8).
  - Illegal combinations: VSEW_INVALID, LMUL_INVALID, LMUL_F8 with SEW16/32, LMUL_F4 with SEW32.
    - Effect: vill=1, vl=0, vsew/lmul/vta/vma cleared, result 0.
  - Legal combinations: vill=0, vsew/lmul/vta=agnostic[0]/vma=agnostic[1] loaded.
    - vlmax=1: vl=VLMAX.
    - keep_vl=1: vl unchanged; if the old vl exceeds the new VLMAX, vill=1 and vl=0.
    - Otherwise: vl=min(rs1_i, VLMAX), unsigned 32-bit compare.
  - Result is the new vl, zero-extended.
  - vstart is cleared.
- Read ops:
  - vtype readback = {vill, 23'b0, vma, vta, 1'b0, vsew, lmul}; equals 0x80000000 when vill=1.
  - vl readback is zero-extended vl.
  - vlenb = VREG_W/8.
- CSR RMW ops (WRITE, SET, CLEAR):
  - Result is the old value, zero-extended.
  - New value: WRITE = src; SET = old|src; CLEAR = old&~src. src is rs1_i truncated to the CSR width.
  - vstart uses VL_W bits, vxsat bit 0, vxrm bits 1:0.
  - vcsr = {vxrm, vxsat} in bits 2:0.
- vxsat_set_i sets vxsat in any cycle. An explicit vxsat/vcsr write in EXEC has priority over vxsat_set_i in the same cycle.
- vl_0_o is derived combinationally from the vl register.
- All config outputs are registered and change only on the edge that leaves EXEC, except vxsat.
- sync_rst_i in any state: return to IDLE and drop any pending result. All registers take their reset values on the next edge.

Optional Feature:
- Macro: VPROC_CFG_VSTART_EN.
- Defined: vstart is a VL_W-bit register as described above.
- Undefined: vstart_o is tied to 0, vstart writes are ignored, vstart reads return 0, and the register is removed.

Decomposition:
- Add to vproc_pkg:
  - cfg_unit_state enum {CFG_IDLE, CFG_DRAIN, CFG_EXEC, CFG_RESP}.
  - vtype bit-position constants VTYPE_VILL_BIT=31, VTYPE_VMA_BIT=7, VTYPE_VTA_BIT=6.
- The unit reuses the existing cfg_vsew, cfg_lmul, cfg_vxrm, cfg_csr_op and op_mode_cfg types.
- One sub-module, vproc_cfg_vlcalc: combinational VLMAX, legality check and vl clamp.

Test Plan:
- Reset values: after reset, CFG_VTYPE_READ -> res_data_o=0x80000000 and vill_o=1.
- Normal vsetvl: CFG_VSETVL, SEW8, LMUL_1, rs1=20, busy_i=0 -> res_valid_o 2 cycles after acceptance, res_data_o=16, vl_o=16, vl_0_o=0.
- vlmax path: CFG_VSETVL, SEW32, LMUL_8, vlmax=1 -> vl_o=32. A following SEW8/LMUL_1 vsetvl with keep_vl=1 (new VLMAX 16) -> vill_o=1, vl_o=0.
- Illegal vtype: LMUL_F8 with SEW32 -> vill_o=1, res_data_o=0, vtype read 0x80000000.
- Drain: CFG_VXRM_WRITE rs1=3 with busy_i high for 5 cycles -> FSM holds in DRAIN for 5 cycles, then res_data_o=0 (old vxrm) and vxrm_o=VXRM_ROD.
- Backpressure and reset: res_ready_i low for 3 cycles -> res_* stable and op_ready_o=0. Then sync_rst_i in RESP -> res_valid_o=0 and op_ready_o=1 on the next cycle.
